// File: rtl/truth_table_sequencer_pkg.sv
// Shared definitions for the truth-table sequencer.
// Contents:
//   state_t        - FSM state encoding (IDLE=0 .. DONE=4, 3 bits)
//   DEFAULT_SETTLE - default settle interval in clock cycles
//   vec_count()    - number of input vectors for a given input count
package truth_table_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int DEFAULT_SETTLE = 1;

  // Vector count is 2**n; shift form keeps it a constant function.
  function automatic int vec_count(input int n);
    return 32'sd1 << n;
  endfunction

endpackage

// File: rtl/truth_table_sequencer_if.sv
// Bus between the sequencer and its environment (gate pair + consumer).
// Signals:
//   start             - single-cycle sweep request
//   vec               - input vector applied to both gate implementations
//   r_a, r_b          - gate implementation outputs (A gate-level, B expression)
//   busy, done        - sweep status
//   table_a, table_b  - captured truth tables, bit k = response to vec==k
//   mismatch          - sticky disagreement flag for the current sweep
//   first_bad         - lowest mismatching vector index
// Modports: slave = sequencer side, master = environment side.
interface truth_table_sequencer_if #(
  parameter int N_IN = 2
);
  logic                     start;
  logic [N_IN-1:0]          vec;
  logic                     r_a;
  logic                     r_b;
  logic                     busy;
  logic                     done;
  logic [(1 << N_IN)-1:0]   table_a;
  logic [(1 << N_IN)-1:0]   table_b;
  logic                     mismatch;
  logic [N_IN-1:0]          first_bad;

  modport slave (
    input  start, r_a, r_b,
    output vec, busy, done, table_a, table_b, mismatch, first_bad
  );

  modport master (
    output start, r_a, r_b,
    input  vec, busy, done, table_a, table_b, mismatch, first_bad
  );
endinterface

// File: rtl/truth_table_sequencer_settle_counter.sv
// 4-bit loadable down-counter used to time the settle interval.
// Ports:
//   clk, reset - clock, asynchronous active-high reset
//   load       - load load_val (has priority over en)
//   load_val   - value to load
//   en         - decrement enable; the count saturates at zero
//   count      - current count
//   zero       - count == 0
module truth_table_sequencer_settle_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  output logic [3:0] count,
  output logic       zero
);

  logic [3:0] count_r;

  // Count register: load, else saturating decrement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= 4'd0;
    end else if (load) begin
      count_r <= load_val;
    end else if (en && (count_r != 4'd0)) begin
      count_r <= count_r - 4'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign zero  = (count_r == 4'd0);

endmodule

// File: rtl/truth_table_sequencer.sv
// Drives every input combination onto a pair of gate implementations in
// ascending order, waits SETTLE cycles per vector, captures both outputs
// into truth-table registers and flags the first disagreement.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous active-high reset
//   bus   - slave side of truth_table_sequencer_if (start, vec, r_a, r_b,
//           busy, done, table_a, table_b, mismatch, first_bad)
// Parameters: N_IN gate inputs, SETTLE cycles per vector (1..15).
module truth_table_sequencer
  import truth_table_sequencer_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int SETTLE = DEFAULT_SETTLE
) (
  input  logic                          clk,
  input  logic                          reset,
  truth_table_sequencer_if.slave        bus
);

  localparam int              NVEC        = vec_count(N_IN);
  localparam logic [N_IN-1:0] LAST_VEC    = N_IN'(NVEC - 1);
  localparam logic [3:0]      SETTLE_LOAD = 4'(SETTLE - 1);

  state_t state_r;
  state_t state_s;

  logic start_s;
  logic sample_s;
  logic cnt_load_s;
  logic cnt_en_s;
  logic [3:0] cnt_s;
  logic cnt_zero_s;

  logic [N_IN-1:0] vec_r;
  logic            busy_r;
  logic            done_r;
  logic [NVEC-1:0] table_a_r;
  logic [NVEC-1:0] table_b_r;
  logic            mismatch_r;
  logic [N_IN-1:0] first_bad_r;

  truth_table_sequencer_settle_counter u_settle (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load_s),
    .load_val (SETTLE_LOAD),
    .en       (cnt_en_s),
    .count    (cnt_s),
    .zero     (cnt_zero_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and per-state control strobes.
  always_comb begin
    state_s    = state_r;
    start_s    = 1'b0;
    sample_s   = 1'b0;
    cnt_load_s = 1'b0;
    cnt_en_s   = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_s = ST_APPLY;
          start_s = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      ST_APPLY: begin
        cnt_load_s = 1'b1;
        if (SETTLE == 1) begin
          state_s = ST_SAMPLE;
        end else begin
          state_s = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        cnt_en_s = 1'b1;
        // Leave on the cycle the decrement lands on zero so SETTLE state
        // lasts exactly SETTLE-1 cycles.
        if (cnt_zero_s || (cnt_s == 4'd1)) begin
          state_s = ST_SAMPLE;
        end else begin
          state_s = ST_SETTLE;
        end
      end
      ST_SAMPLE: begin
        sample_s = 1'b1;
        if (vec_r == LAST_VEC) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_APPLY;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Vector register, status flags and truth-table capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vec_r       <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      table_a_r   <= '0;
      table_b_r   <= '0;
      mismatch_r  <= 1'b0;
      first_bad_r <= '0;
    end else if (start_s) begin
      vec_r       <= '0;
      busy_r      <= 1'b1;
      done_r      <= 1'b0;
      table_a_r   <= '0;
      table_b_r   <= '0;
      mismatch_r  <= 1'b0;
      first_bad_r <= '0;
    end else if (sample_s) begin
      table_a_r[vec_r] <= bus.r_a;
      table_b_r[vec_r] <= bus.r_b;
      // Only the first disagreement records its index; sweep order is
      // ascending, so that is the lowest one.
      if ((bus.r_a != bus.r_b) && !mismatch_r) begin
        mismatch_r  <= 1'b1;
        first_bad_r <= vec_r;
      end
      if (vec_r == LAST_VEC) begin
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end else begin
        vec_r <= vec_r + N_IN'(1);
      end
    end
  end

  assign bus.vec       = vec_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.table_a   = table_a_r;
  assign bus.table_b   = table_b_r;
  assign bus.mismatch  = mismatch_r;
  assign bus.first_bad = first_bad_r;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench for truth_table_sequencer: two instances (SETTLE=1 and
// SETTLE=3) each wrapped around a NAND-built AND (A) and an expression
// gate (B) that can be switched from AND to OR on the SETTLE=1 instance.
module tb_truth_table_sequencer;

  localparam int F_VEC = 0, F_BUSY = 1, F_DONE = 2, F_TA = 3, F_TB = 4,
                 F_MIS = 5, F_FB = 6;

  logic clk;
  logic reset;
  logic b_or;

  int n_checks;
  int n_errors;

  truth_table_sequencer_if #(.N_IN(2)) bus1 ();
  truth_table_sequencer_if #(.N_IN(2)) bus3 ();

  truth_table_sequencer #(.N_IN(2), .SETTLE(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  truth_table_sequencer #(.N_IN(2), .SETTLE(3)) u_dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  function automatic logic nand_and(input logic a, input logic b);
    logic n;
    n = ~(a & b);
    return ~(n & n);
  endfunction

  assign bus1.r_a = nand_and(bus1.vec[0], bus1.vec[1]);
  assign bus1.r_b = b_or ? (bus1.vec[0] | bus1.vec[1]) : (bus1.vec[0] & bus1.vec[1]);
  assign bus3.r_a = nand_and(bus3.vec[0], bus3.vec[1]);
  assign bus3.r_b = bus3.vec[0] & bus3.vec[1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] obs(input int sel, input int f);
    logic [31:0] v;
    v = 32'd0;
    if (sel == 0) begin
      case (f)
        F_VEC:  v = 32'(bus1.vec);
        F_BUSY: v = 32'(bus1.busy);
        F_DONE: v = 32'(bus1.done);
        F_TA:   v = 32'(bus1.table_a);
        F_TB:   v = 32'(bus1.table_b);
        F_MIS:  v = 32'(bus1.mismatch);
        default: v = 32'(bus1.first_bad);
      endcase
    end else begin
      case (f)
        F_VEC:  v = 32'(bus3.vec);
        F_BUSY: v = 32'(bus3.busy);
        F_DONE: v = 32'(bus3.done);
        F_TA:   v = 32'(bus3.table_a);
        F_TB:   v = 32'(bus3.table_b);
        F_MIS:  v = 32'(bus3.mismatch);
        default: v = 32'(bus3.first_bad);
      endcase
    end
    return v;
  endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) bus1.start = v;
    else          bus3.start = v;
  endtask

  // Full sweep: start pulse, per-cycle vec check, done latency and end state.
  // restart_at > 0 raises start again that many cycles after the start edge.
  task automatic run_sweep(input int sel, input int settle, input int restart_at);
    int cyc;
    int ev;
    @(negedge clk);
    set_start(sel, 1'b1);
    @(posedge clk);
    #1;
    set_start(sel, 1'b0);
    check_eq("busy_at_start", obs(sel, F_BUSY), 32'd1);
    check_eq("done_at_start", obs(sel, F_DONE), 32'd0);
    check_eq("vec_at_start",  obs(sel, F_VEC),  32'd0);
    check_eq("ta_cleared",    obs(sel, F_TA),   32'd0);
    check_eq("tb_cleared",    obs(sel, F_TB),   32'd0);
    check_eq("mis_cleared",   obs(sel, F_MIS),  32'd0);
    cyc = 0;
    while ((obs(sel, F_DONE) == 32'd0) && (cyc < 200)) begin
      @(posedge clk);
      #1;
      cyc++;
      set_start(sel, (cyc == restart_at));
      ev = cyc / (settle + 1);
      if (ev > 3) ev = 3;
      check_eq("vec_seq", obs(sel, F_VEC), 32'(ev));
    end
    set_start(sel, 1'b0);
    check_eq("done_latency", 32'(cyc), 32'(4 * (settle + 1)));
    check_eq("busy_at_done", obs(sel, F_BUSY), 32'd0);
    check_eq("vec_at_done",  obs(sel, F_VEC),  32'd3);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    b_or       = 1'b0;
    reset      = 1'b0;
    bus1.start = 1'b0;
    bus3.start = 1'b0;
    #1 reset = 1'b1;
    #2;
    check_eq("rst_vec",  obs(0, F_VEC),  32'd0);
    check_eq("rst_busy", obs(0, F_BUSY), 32'd0);
    check_eq("rst_done", obs(0, F_DONE), 32'd0);
    check_eq("rst_ta",   obs(0, F_TA),   32'd0);
    check_eq("rst_tb",   obs(0, F_TB),   32'd0);
    check_eq("rst_mis",  obs(0, F_MIS),  32'd0);
    check_eq("rst_fb",   obs(0, F_FB),   32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Correct gate pair, SETTLE=1.
    run_sweep(0, 1, 0);
    check_eq("and_ta",  obs(0, F_TA),  32'h8);
    check_eq("and_tb",  obs(0, F_TB),  32'h8);
    check_eq("and_mis", obs(0, F_MIS), 32'd0);

    // B replaced by OR.
    b_or = 1'b1;
    run_sweep(0, 1, 0);
    check_eq("or_ta",  obs(0, F_TA),  32'h8);
    check_eq("or_tb",  obs(0, F_TB),  32'hE);
    check_eq("or_mis", obs(0, F_MIS), 32'd1);
    check_eq("or_fb",  obs(0, F_FB),  32'd1);

    // SETTLE=3, correct gates.
    run_sweep(1, 3, 0);
    check_eq("s3_ta",  obs(1, F_TA),  32'h8);
    check_eq("s3_tb",  obs(1, F_TB),  32'h8);
    check_eq("s3_mis", obs(1, F_MIS), 32'd0);

    // Second start during the sweep is ignored.
    b_or = 1'b0;
    run_sweep(0, 1, 3);
    check_eq("rs_ta",  obs(0, F_TA),  32'h8);
    check_eq("rs_tb",  obs(0, F_TB),  32'h8);
    check_eq("rs_mis", obs(0, F_MIS), 32'd0);

    // Asynchronous reset in the middle of a sweep (vec==2).
    b_or = 1'b1;
    @(negedge clk);
    bus1.start = 1'b1;
    @(posedge clk);
    #1;
    bus1.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("mid_vec", obs(0, F_VEC), 32'd2);
    check_eq("mid_tb",  obs(0, F_TB),  32'h2);
    check_eq("mid_mis", obs(0, F_MIS), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("arst_vec",  obs(0, F_VEC),  32'd0);
    check_eq("arst_busy", obs(0, F_BUSY), 32'd0);
    check_eq("arst_done", obs(0, F_DONE), 32'd0);
    check_eq("arst_ta",   obs(0, F_TA),   32'd0);
    check_eq("arst_tb",   obs(0, F_TB),   32'd0);
    check_eq("arst_mis",  obs(0, F_MIS),  32'd0);
    @(negedge clk);
    reset = 1'b0;
    b_or  = 1'b0;
    run_sweep(0, 1, 0);
    check_eq("post_ta",  obs(0, F_TA),  32'h8);
    check_eq("post_tb",  obs(0, F_TB),  32'h8);
    check_eq("post_mis", obs(0, F_MIS), 32'd0);

    // Back-to-back sweep from DONE with B switched to OR.
    b_or = 1'b1;
    run_sweep(0, 1, 0);
    check_eq("b2b_ta",  obs(0, F_TA),  32'h8);
    check_eq("b2b_tb",  obs(0, F_TB),  32'hE);
    check_eq("b2b_mis", obs(0, F_MIS), 32'd1);
    check_eq("b2b_fb",  obs(0, F_FB),  32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/truth_table_sequencer.md
Name: truth_table_sequencer

Overview:
Stimulus-and-capture stage wrapped around a pair of combinational gate implementations, such as a NAND-built AND and its expression form. On start, it drives every input combination onto the gate inputs in ascending binary order and waits a settle interval per vector. It then samples both implementations' outputs into truth-table registers and flags any disagreement. It sits directly upstream of the gates, feeding their inputs, and directly downstream of them, consuming their results.

Parameters:
N_IN, 2, number of gate inputs driven; vector count is 2**N_IN
SETTLE, 1, clock cycles between applying a vector and sampling outputs (1..15)

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to run a full sweep; ignored unless idle or done
vec  output  N_IN  current input vector driven to both gate implementations
r_a  input  1  output of implementation A (gate-level)
r_b  input  1  output of implementation B (expression)
busy  output  1  high while a sweep is in progress
done  output  1  high from sweep completion until next start or reset
table_a  output  2**N_IN  captured outputs of A; bit k = response to vec==k
table_b  output  2**N_IN  captured outputs of B; bit k = response to vec==k
mismatch  output  1  sticky; set if r_a != r_b on any sampled vector of the current sweep
first_bad  output  N_IN  lowest vector index that mismatched; valid when mismatch=1

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high. While reset is asserted, regardless of clk:
  - state = IDLE
  - vec = 0, busy = 0, done = 0
  - table_a = 0, table_b = 0
  - mismatch = 0, first_bad = 0
- States: IDLE, APPLY, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 -> APPLY.
  - On that edge: vec=0, tables cleared, mismatch cleared, first_bad cleared, busy=1.
- APPLY:
  - vec is stable from this cycle.
  - Settle counter loads SETTLE-1.
  - Next state is SETTLE, or SAMPLE directly if SETTLE==1.
- SETTLE:
  - Counter decrements each cycle.
  - At 0 -> SAMPLE.
- SAMPLE:
  - table_a[vec] <= r_a; table_b[vec] <= r_b.
  - If r_a != r_b and mismatch==0: mismatch <= 1, first_bad <= vec.
  - If r_a != r_b and mismatch is already 1: mismatch stays 1, first_bad unchanged (lowest index is kept).
  - If vec == 2**N_IN-1 -> DONE, busy <= 0, done <= 1.
  - Otherwise vec <= vec+1 and next state is APPLY.
- Cycles per vector: 1 (APPLY) + (SETTLE-1) (SETTLE) + 1 (SAMPLE) = SETTLE+1.
  - Total sweep = 2**N_IN*(SETTLE+1) cycles from the start edge to done rising.
  - N_IN=2, SETTLE=1: done rises 8 cycles after start.
- DONE:
  - Outputs hold; vec holds 2**N_IN-1.
  - start=1 -> same as the IDLE start transition (done<=0, busy<=1, clear, vec=0).
- start while busy: ignored; no restart, no effect on the current sweep.
- Wrap-around: vec never wraps past the last index; the sweep terminates at the last vector.
- Reset mid-sweep: immediate return to all reset values; partial tables are discarded.
- r_a/r_b are only sampled in SAMPLE; values in other states are don't-care.

Decomposition:
- Shared package: state encoding constants (IDLE=0 .. DONE=4, 3 bits), default SETTLE, vector-count function 2**N_IN.
- Sub-module settle_counter: 4-bit loadable down-counter with load, enable and zero flag, instantiated once.
- FSM, vector register and capture logic stay in the top module.

Test Plan:
- AND vs NAND-AND, N_IN=2, SETTLE=1, one start pulse -> done high 8 cycles later; table_a=table_b=4'b1000; mismatch=0; busy low at done.
- B tied to an OR gate, A to AND -> table_a=4'b1000, table_b=4'b1110, mismatch=1, first_bad=2'b01.
- SETTLE=3, correct gates -> vec holds each value for 4 cycles; done rises 16 cycles after start; tables=4'b1000.
- start pulsed again at cycle 3 of a sweep -> ignored; done still rises at cycle 8; tables unchanged from the single-sweep result.
- reset asserted asynchronously mid-sweep (vec=2) -> vec=0, busy=0, done=0, tables=0 immediately, without waiting for a clk edge; a new start then gives the full correct sweep.
- Back-to-back sweeps: after done, start with B switched from correct to OR -> tables and mismatch cleared at start; second result has mismatch=1, first_bad=1.
